tm_engine: RTL and testbench

// Programmable single-tape Turing-machine engine for the tm lab family. Replaces the hard-coded

---
 rtl/tm_pkg.sv | 36 +++
 rtl/tm_if.sv | 52 +++++
 rtl/tm_classifier.sv | 30 +++
 rtl/tm_engine.sv | 176 +++++++++++++++++
 tb/tb_tm_engine.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tm_pkg.sv
// Shared types for the tm engine family: rule word layout, head moves,
// halt reason codes and the symbol-class width helper.
package tm_pkg;

  localparam int SYM_W   = 8;
  localparam int STATE_W = 4;

  typedef enum logic [1:0] {
    MOVE_STAY = 2'd0,
    MOVE_R    = 2'd1,
    MOVE_L    = 2'd2
  } move_e;

  typedef enum logic [2:0] {
    HALT_ACCEPT  = 3'd0,
    HALT_NO_RULE = 3'd1,
    HALT_EDGE_L  = 3'd2,
    HALT_EDGE_R  = 3'd3,
    HALT_TIMEOUT = 3'd4
  } halt_e;

  // move is kept as raw bits: encoding 3 is a legal "stay" that the enum cannot name
  typedef struct packed {
    logic [STATE_W-1:0] next_state;
    logic               wr_en;
    logic [SYM_W-1:0]   wr_sym;
    logic [1:0]         move;
    logic               halt;
  } rule_t;

  // Class codes 0..alpha_n-1 are alphabet hits, alpha_n means "other"
  function automatic int cls_w(input int alpha_n);
    return $clog2(alpha_n + 1);
  endfunction

endpackage

// File: rtl/tm_if.sv
// Host-side bus of the tm engine: alphabet/rule/tape configuration, run
// control and halt status. master = host, slave = engine.
interface tm_if #(
  parameter int ALPHA_N    = 4,
  parameter int TAPE_DEPTH = 64,
  parameter int MAX_STEPS  = 1024
) ();
  import tm_pkg::*;

  localparam int AIDX_W = (ALPHA_N > 1) ? $clog2(ALPHA_N) : 1;
  localparam int CLS_W  = cls_w(ALPHA_N);
  localparam int ADDR_W = $clog2(TAPE_DEPTH);
  localparam int CNT_W  = $clog2(MAX_STEPS + 1);

  logic                alpha_we;
  logic [AIDX_W-1:0]   alpha_idx;
  logic [SYM_W-1:0]    alpha_sym;
  logic                rule_we;
  logic [STATE_W-1:0]  rule_state;
  logic [CLS_W-1:0]    rule_cls;
  rule_t               rule_wdata;
  logic                tape_we;
  logic [ADDR_W-1:0]   tape_addr;
  logic [SYM_W-1:0]    tape_wdata;
  logic [SYM_W-1:0]    tape_rdata;
  logic                start;
  logic [STATE_W-1:0]  start_state;
  logic [ADDR_W-1:0]   start_head;
  logic                busy;
  logic                done;
  logic [2:0]          halt_code;
  logic [STATE_W-1:0]  cur_state;
  logic [ADDR_W-1:0]   head;
  logic [CNT_W-1:0]    step_cnt;

  modport master (
    output alpha_we, alpha_idx, alpha_sym,
    output rule_we, rule_state, rule_cls, rule_wdata,
    output tape_we, tape_addr, tape_wdata,
    output start, start_state, start_head,
    input  tape_rdata, busy, done, halt_code, cur_state, head, step_cnt
  );

  modport slave (
    input  alpha_we, alpha_idx, alpha_sym,
    input  rule_we, rule_state, rule_cls, rule_wdata,
    input  tape_we, tape_addr, tape_wdata,
    input  start, start_state, start_head,
    output tape_rdata, busy, done, halt_code, cur_state, head, step_cnt
  );

endinterface

// File: rtl/tm_classifier.sv
// Maps a tape symbol to its class: the lowest alphabet index holding that
// symbol, or ALPHA_N when no entry matches.
module tm_classifier
  import tm_pkg::*;
#(
  parameter int ALPHA_N = 4,
  parameter int CLS_W   = cls_w(4)
) (
  input  logic [SYM_W-1:0] sym,
  input  logic [SYM_W-1:0] alpha [ALPHA_N],
  output logic [CLS_W-1:0] cls
);

  logic [ALPHA_N-1:0] hit;

  generate
    for (genvar gi = 0; gi < ALPHA_N; gi++) begin : g_hit
      assign hit[gi] = (alpha[gi] == sym);
    end
  endgenerate

  // Priority pick: scanning downward lets the lowest matching index win
  always_comb begin
    cls = CLS_W'(ALPHA_N);
    for (int i = ALPHA_N - 1; i >= 0; i--) begin
      if (hit[i]) cls = CLS_W'(i);
    end
  end

endmodule

// File: rtl/tm_engine.sv
// Programmable single-tape Turing machine: run-time loaded alphabet and
// rule table, internal tape, one step per clock with a bounded step budget.
module tm_engine
  import tm_pkg::*;
#(
  parameter int ALPHA_N    = 4,
  parameter int TAPE_DEPTH = 64,
  parameter int MAX_STEPS  = 1024
) (
  input logic clk,
  input logic reset,
  tm_if.slave bus
);

  localparam int AIDX_W = (ALPHA_N > 1) ? $clog2(ALPHA_N) : 1;
  localparam int CLS_W  = cls_w(ALPHA_N);
  localparam int ADDR_W = $clog2(TAPE_DEPTH);
  localparam int CNT_W  = $clog2(MAX_STEPS + 1);
  localparam int RULE_N = 2 ** (STATE_W + CLS_W);

  localparam logic [ADDR_W-1:0] HEAD_LAST = ADDR_W'(TAPE_DEPTH - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_STEPS);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} fsm_e;

  fsm_e                 fsm_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [2:0]           halt_code_reg;
  logic [STATE_W-1:0]   cur_state_reg;
  logic [ADDR_W-1:0]    head_reg;
  logic [CNT_W-1:0]     step_cnt_reg;
  logic [RULE_N-1:0]    rule_valid_reg;

  logic [SYM_W-1:0]     alpha_reg [ALPHA_N];
  rule_t                rule_mem  [RULE_N];
  logic [SYM_W-1:0]     tape_mem  [TAPE_DEPTH];

  logic                 cfg_ok;
  logic [SYM_W-1:0]     cur_sym;
  logic [CLS_W-1:0]     cur_cls;
  logic [STATE_W+CLS_W-1:0] rule_idx;
  rule_t                cur_rule;
  logic                 cur_valid;
  logic [CNT_W-1:0]     step_next;
  logic                 halt_now;
  halt_e                halt_kind;
  logic [ADDR_W-1:0]    head_next;

  // Host configuration is only accepted while idle and not being reset
  assign cfg_ok = !reset && (fsm_reg == ST_IDLE);

  assign cur_sym   = tape_mem[head_reg];
  assign rule_idx  = {cur_state_reg, cur_cls};
  assign cur_rule  = rule_mem[rule_idx];
  assign cur_valid = rule_valid_reg[rule_idx];
  assign step_next = step_cnt_reg + CNT_W'(1);

  tm_classifier #(
    .ALPHA_N (ALPHA_N),
    .CLS_W   (CLS_W)
  ) u_classifier (
    .sym   (cur_sym),
    .alpha (alpha_reg),
    .cls   (cur_cls)
  );

  generate
    for (genvar gi = 0; gi < ALPHA_N; gi++) begin : g_alpha
      // Alphabet entry gi: host write, survives reset
      always_ff @(posedge clk) begin
        if (cfg_ok && bus.alpha_we && bus.alpha_idx == AIDX_W'(gi))
          alpha_reg[gi] <= bus.alpha_sym;
      end
    end
  endgenerate

  // Rule payloads: host write; validity is tracked separately so reset can clear it
  always_ff @(posedge clk) begin
    if (cfg_ok && bus.rule_we)
      rule_mem[{bus.rule_state, bus.rule_cls}] <= bus.rule_wdata;
  end

  // Tape: engine writes while running, host writes while idle; a reset edge writes nothing
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fsm_reg == ST_RUN) begin
        if (cur_valid && cur_rule.wr_en)
          tape_mem[head_reg] <= cur_rule.wr_sym;
      end else if (bus.tape_we) begin
        tape_mem[bus.tape_addr] <= bus.tape_wdata;
      end
    end
  end

  // Outcome of the current step, in precedence order: missing rule, halt bit, edges, budget
  always_comb begin
    halt_now  = 1'b0;
    halt_kind = HALT_ACCEPT;
    head_next = head_reg;
    if (!cur_valid) begin
      halt_now  = 1'b1;
      halt_kind = HALT_NO_RULE;
    end else if (cur_rule.halt) begin
      halt_now  = 1'b1;
      halt_kind = HALT_ACCEPT;
    end else if (cur_rule.move == MOVE_L && head_reg == '0) begin
      halt_now  = 1'b1;
      halt_kind = HALT_EDGE_L;
    end else if (cur_rule.move == MOVE_R && head_reg == HEAD_LAST) begin
      halt_now  = 1'b1;
      halt_kind = HALT_EDGE_R;
    end else begin
      if (cur_rule.move == MOVE_L)
        head_next = head_reg - ADDR_W'(1);
      else if (cur_rule.move == MOVE_R)
        head_next = head_reg + ADDR_W'(1);
      if (step_next == MAX_CNT) begin
        halt_now  = 1'b1;
        halt_kind = HALT_TIMEOUT;
      end
    end
  end

  // Control FSM: idle configuration/start, then one machine step per clock until halt
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg        <= ST_IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      halt_code_reg  <= 3'd0;
      cur_state_reg  <= '0;
      head_reg       <= '0;
      step_cnt_reg   <= '0;
      rule_valid_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        ST_IDLE: begin
          if (bus.rule_we)
            rule_valid_reg[{bus.rule_state, bus.rule_cls}] <= 1'b1;
          if (bus.start) begin
            fsm_reg       <= ST_RUN;
            busy_reg      <= 1'b1;
            cur_state_reg <= bus.start_state;
            head_reg      <= bus.start_head;
            step_cnt_reg  <= '0;
          end
        end
        ST_RUN: begin
          if (cur_valid) begin
            cur_state_reg <= cur_rule.next_state;
            step_cnt_reg  <= step_next;
          end
          head_reg <= head_next;
          if (halt_now) begin
            fsm_reg       <= ST_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            halt_code_reg <= halt_kind;
          end
        end
        default: fsm_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.tape_rdata = tape_mem[bus.tape_addr];
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.halt_code  = halt_code_reg;
  assign bus.cur_state  = cur_state_reg;
  assign bus.head       = head_reg;
  assign bus.step_cnt   = step_cnt_reg;

endmodule

// File: tb/tb_tm_engine.sv
// Bench for tm_engine: directed runs plus randomized programs, each compared
// against a step-by-step behavioural machine kept in plain arrays.
module tb_tm_engine;
  import tm_pkg::*;

  localparam int ALPHA_N    = 4;
  localparam int TAPE_DEPTH = 64;
  localparam int MAX_STEPS  = 16;
  localparam int CLS_N      = 8;
  localparam int N_STATES   = 16;

  localparam logic [7:0] S_OPEN  = 8'h28;
  localparam logic [7:0] S_CLOSE = 8'h29;
  localparam logic [7:0] S_F     = 8'h46;
  localparam logic [7:0] S_T     = 8'h54;
  localparam logic [7:0] S_OTHER = 8'h55;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tm_if #(.ALPHA_N(ALPHA_N), .TAPE_DEPTH(TAPE_DEPTH), .MAX_STEPS(MAX_STEPS)) bus ();

  tm_engine #(.ALPHA_N(ALPHA_N), .TAPE_DEPTH(TAPE_DEPTH), .MAX_STEPS(MAX_STEPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference machine state
  logic [7:0] m_alpha [ALPHA_N];
  rule_t      m_rule  [N_STATES*CLS_N];
  bit         m_valid [N_STATES*CLS_N];
  logic [7:0] m_tape  [TAPE_DEPTH];

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_alpha(input int i, input logic [7:0] s);
    bus.alpha_we = 1'b1; bus.alpha_idx = 2'(i); bus.alpha_sym = s;
    tick();
    bus.alpha_we = 1'b0;
    m_alpha[i] = s;
  endtask

  task automatic wr_rule(input int st, input int cls, input int nxt, input bit we,
                         input logic [7:0] ws, input int mv, input bit h);
    rule_t r;
    r.next_state = 4'(nxt); r.wr_en = we; r.wr_sym = ws; r.move = 2'(mv); r.halt = h;
    bus.rule_we = 1'b1; bus.rule_state = 4'(st); bus.rule_cls = 3'(cls); bus.rule_wdata = r;
    tick();
    bus.rule_we = 1'b0;
    m_rule[st*CLS_N+cls]  = r;
    m_valid[st*CLS_N+cls] = 1'b1;
  endtask

  task automatic wr_tape(input int a, input logic [7:0] d);
    bus.tape_we = 1'b1; bus.tape_addr = 6'(a); bus.tape_wdata = d;
    tick();
    bus.tape_we = 1'b0;
    m_tape[a] = d;
  endtask

  task automatic rd_tape(input int a, output logic [7:0] d);
    bus.tape_addr = 6'(a);
    #1;
    d = bus.tape_rdata;
  endtask

  // Behavioural machine: follow the rules cell by cell until a halt condition
  task automatic m_run(input int st, input int hd, output int code, output int fst,
                       output int fhd, output int steps);
    bit fin;
    int cls, key;
    rule_t r;
    fin = 0; steps = 0; code = 0;
    while (!fin) begin
      cls = ALPHA_N;
      for (int i = 0; i < ALPHA_N; i++)
        if (cls == ALPHA_N && m_alpha[i] === m_tape[hd]) cls = i;
      key = st*CLS_N + cls;
      if (!m_valid[key]) begin
        code = 1; fin = 1;
      end else begin
        r = m_rule[key];
        if (r.wr_en) m_tape[hd] = r.wr_sym;
        st = int'(r.next_state);
        steps++;
        if (r.halt) begin
          code = 0; fin = 1;
        end else if (r.move == 2'd2 && hd == 0) begin
          code = 2; fin = 1;
        end else if (r.move == 2'd1 && hd == TAPE_DEPTH-1) begin
          code = 3; fin = 1;
        end else begin
          if (r.move == 2'd2) hd--;
          else if (r.move == 2'd1) hd++;
          if (steps == MAX_STEPS) begin code = 4; fin = 1; end
        end
      end
    end
    fst = st; fhd = hd;
  endtask

  task automatic cmp_tape(input string tag);
    int mism, first;
    logic [7:0] d;
    mism = 0; first = -1;
    for (int a = 0; a < TAPE_DEPTH; a++) begin
      rd_tape(a, d);
      if (d !== m_tape[a]) begin
        mism++;
        if (first < 0) first = a;
      end
    end
    check({tag, ".tape_mismatch_cells(first=", $sformatf("%0d", first), ")"}, mism, 0);
  endtask

  // One run: optional tape write concurrent with start, optional config pokes while busy
  task automatic run_check(input string tag, input int st, input int hd,
                           input bit sw, input int sa, input logic [7:0] sd, input bit poke);
    int code, fst, fhd, steps, lat, dcnt;
    rule_t pr;
    if (sw) m_tape[sa] = sd;
    m_run(st, hd, code, fst, fhd, steps);
    bus.start = 1'b1; bus.start_state = 4'(st); bus.start_head = 6'(hd);
    bus.tape_we = sw; bus.tape_addr = 6'(sa); bus.tape_wdata = sd;
    tick();
    bus.start = 1'b0; bus.tape_we = 1'b0;
    check({tag, ".busy_after_start"}, bus.busy, 1);
    pr = '0; pr.halt = 1'b1;
    dcnt = 0; lat = -1;
    for (int c = 1; c <= MAX_STEPS + 6; c++) begin
      bus.tape_we    = poke && c <= 3;
      bus.tape_addr  = 6'd12;
      bus.tape_wdata = 8'hAA;
      bus.rule_we    = poke && c <= 3;
      bus.rule_state = 4'd8;
      bus.rule_cls   = 3'd4;
      bus.rule_wdata = pr;
      tick();
      if (bus.done) begin
        dcnt++;
        if (lat < 0) lat = c;
      end
    end
    bus.tape_we = 1'b0; bus.rule_we = 1'b0;
    check({tag, ".done_pulses"}, dcnt, 1);
    check({tag, ".done_latency"}, lat, steps + ((code == 1) ? 1 : 0));
    check({tag, ".halt_code"}, bus.halt_code, code);
    check({tag, ".cur_state"}, bus.cur_state, fst);
    check({tag, ".head"}, bus.head, fhd);
    check({tag, ".step_cnt"}, bus.step_cnt, steps);
    check({tag, ".busy_after_halt"}, bus.busy, 0);
    cmp_tape(tag);
    $display("run %s: state=%0d head=%0d -> halt_code=%0d steps=%0d final_state=%0d final_head=%0d",
             tag, st, hd, code, steps, fst, fhd);
  endtask

  logic [7:0] pool [6];

  initial begin
    int len, dcnt;
    logic [7:0] d;

    pool[0] = S_OPEN; pool[1] = S_CLOSE; pool[2] = S_F;
    pool[3] = S_T;    pool[4] = S_OTHER; pool[5] = 8'h00;

    bus.alpha_we = 0; bus.alpha_idx = '0; bus.alpha_sym = '0;
    bus.rule_we = 0; bus.rule_state = '0; bus.rule_cls = '0; bus.rule_wdata = '0;
    bus.tape_we = 0; bus.tape_addr = '0; bus.tape_wdata = '0;
    bus.start = 0; bus.start_state = '0; bus.start_head = '0;

    tick(); tick();
    reset = 1'b0;
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.halt_code", bus.halt_code, 0);
    check("reset.cur_state", bus.cur_state, 0);
    check("reset.head", bus.head, 0);
    check("reset.step_cnt", bus.step_cnt, 0);

    for (int a = 0; a < TAPE_DEPTH; a++) wr_tape(a, 8'h00);
    wr_alpha(0, S_OPEN); wr_alpha(1, S_CLOSE); wr_alpha(2, S_F); wr_alpha(3, S_T);

    // No rules loaded: immediate NO_RULE halt
    run_check("empty_rules", 0, 0, 0, 0, 8'h00, 0);
    check("empty_rules.code_const", bus.halt_code, 1);

    // Bracket checker: state = nesting depth, verdict written on the terminator
    for (int s = 0; s < N_STATES; s++) begin
      if (s < N_STATES-1) wr_rule(s, 0, s+1, 0, 8'h00, 1, 0);
      else                wr_rule(s, 0, s, 1, S_F, 0, 1);
      if (s > 0) wr_rule(s, 1, s-1, 0, 8'h00, 1, 0);
      else       wr_rule(s, 1, 0, 1, S_F, 0, 1);
      wr_rule(s, 4, s, 1, (s == 0) ? S_T : S_F, 0, 1);
    end
    wr_tape(1, S_OPEN); wr_tape(2, S_CLOSE); wr_tape(3, S_CLOSE); wr_tape(4, 8'h00);
    run_check("bracket_balanced", 0, 0, 1, 0, S_OPEN, 0);
    rd_tape(4, d);
    check("bracket_balanced.verdict", d, S_T);
    check("bracket_balanced.steps_const", bus.step_cnt, 5);

    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(1, 10);
      for (int a = 1; a < len; a++) wr_tape(a, ($urandom % 2) ? S_OPEN : S_CLOSE);
      wr_tape(len, 8'h00);
      run_check($sformatf("bracket_rand%0d", k), 0, 0, 1, 0,
                ($urandom % 2) ? S_OPEN : S_CLOSE, 0);
    end

    // Move left off cell 0: write still lands, head stays
    wr_tape(0, S_OTHER);
    wr_rule(5, 4, 6, 1, 8'h5A, 2, 0);
    run_check("edge_left", 5, 0, 0, 0, 8'h00, 0);
    check("edge_left.code_const", bus.halt_code, 2);
    check("edge_left.head_const", bus.head, 0);
    rd_tape(0, d);
    check("edge_left.written", d, 8'h5A);

    // Move right off the last cell
    wr_tape(TAPE_DEPTH-1, S_OTHER);
    wr_rule(6, 4, 7, 0, 8'h00, 1, 0);
    run_check("edge_right", 6, TAPE_DEPTH-1, 0, 0, 8'h00, 0);
    check("edge_right.code_const", bus.halt_code, 3);
    check("edge_right.head_const", bus.head, TAPE_DEPTH-1);

    // Self-loop stay rules exhaust the budget; config pokes during the run must be ignored
    wr_tape(10, S_OTHER);
    wr_rule(8, 4, 8, 0, 8'h00, 0, 0);
    run_check("timeout_stay0", 8, 10, 0, 0, 8'h00, 1);
    check("timeout_stay0.code_const", bus.halt_code, 4);
    check("timeout_stay0.steps_const", bus.step_cnt, MAX_STEPS);
    wr_rule(9, 4, 9, 1, S_OTHER, 3, 0);
    run_check("timeout_stay3", 9, 10, 0, 0, 8'h00, 0);

    // Duplicate alphabet entry: lowest index decides the class
    wr_alpha(2, S_OPEN);
    wr_rule(14, 0, 2, 0, 8'h00, 0, 1);
    wr_rule(14, 2, 3, 0, 8'h00, 0, 1);
    wr_rule(14, 6, 9, 0, 8'h00, 0, 1);
    wr_tape(30, S_OPEN);
    run_check("dup_alpha", 14, 30, 0, 0, 8'h00, 0);
    check("dup_alpha.state_const", bus.cur_state, 2);

    // Random programs over states 10..13
    for (int s = 10; s <= 13; s++)
      for (int c = 0; c <= ALPHA_N; c++)
        if ($urandom % 6 != 0)
          wr_rule(s, c, $urandom_range(10, 13), $urandom % 2, pool[$urandom % 6],
                  $urandom % 4, ($urandom % 8) == 0);
    for (int a = 20; a <= 40; a++) wr_tape(a, pool[$urandom % 6]);
    for (int k = 0; k < 4; k++)
      run_check($sformatf("random%0d", k), $urandom_range(10, 13), $urandom_range(20, 40),
                0, 0, 8'h00, 0);

    // Reset after three steps of a right-walking writer
    wr_rule(11, 4, 11, 1, 8'h57, 1, 0);
    for (int a = 40; a <= 45; a++) wr_tape(a, S_OTHER);
    wr_tape(50, S_OTHER);
    bus.start = 1'b1; bus.start_state = 4'd11; bus.start_head = 6'd40;
    tick();
    bus.start = 1'b0;
    dcnt = 0;
    bus.tape_we = 1'b1; bus.tape_addr = 6'd50; bus.tape_wdata = 8'hAA;
    tick();
    if (bus.done) dcnt++;
    bus.tape_we = 1'b0;
    tick();
    if (bus.done) dcnt++;
    tick();
    if (bus.done) dcnt++;
    reset = 1'b1;
    tick();
    if (bus.done) dcnt++;
    reset = 1'b0;
    tick();
    if (bus.done) dcnt++;
    for (int a = 40; a <= 42; a++) m_tape[a] = 8'h57;
    for (int i = 0; i < N_STATES*CLS_N; i++) m_valid[i] = 1'b0;
    check("midrun_reset.busy", bus.busy, 0);
    check("midrun_reset.no_done", dcnt, 0);
    check("midrun_reset.step_cnt", bus.step_cnt, 0);
    check("midrun_reset.head", bus.head, 0);
    rd_tape(42, d);
    check("midrun_reset.step3_write", d, 8'h57);
    rd_tape(43, d);
    check("midrun_reset.no_step4_write", d, S_OTHER);
    cmp_tape("midrun_reset");
    run_check("after_reset", 11, 40, 0, 0, 8'h00, 0);
    check("after_reset.code_const", bus.halt_code, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
